// File: rtl/cycle_sequencer.sv
// cycle_sequencer: one-hot T-state / M-cycle timing generator with wait-state
// stalling, HALT/wake handling and a sticky overrun flag.
module cycle_sequencer #(
    parameter int STEPS      = 4,
    parameter int MAX_CYCLES = 8,
    parameter int WAIT_STEP  = 1
) (
    input  logic                          i_Clk,
    input  logic                          i_Reset,
    input  logic                          i_Enable,
    input  logic                          i_Wait,
    input  logic                          i_Last_Cycle,
    input  logic                          i_Halt,
    input  logic                          i_Wake,
    output logic [STEPS-1:0]              o_Cycle_Step,
    output logic [MAX_CYCLES-1:0]         o_Cycle_Count,
    output logic [$clog2(MAX_CYCLES)-1:0] o_M_Index,
    output logic                          o_Cycle_End,
    output logic                          o_Instr_Start,
    output logic                          o_Halted,
    output logic                          o_Overrun
);
    localparam int MW = $clog2(MAX_CYCLES);
    typedef enum logic [1:0] {IDLE, RUN, HALTED} state_t;
    state_t                  state_q, state_d;
    logic [STEPS-1:0]        step_q, step_d;
    logic [MAX_CYCLES-1:0]   count_q, count_d;
    logic [MW-1:0]           idx_q, idx_d;
    logic                    overrun_q, overrun_d;
    logic                    run, stall;
    assign run           = state_q == RUN;
    assign stall         = run && step_q[WAIT_STEP] && i_Wait;
    assign o_Cycle_End   = run && step_q[STEPS-1] && !stall;
    assign o_Instr_Start = run && step_q[0] && count_q[0];
    assign o_Halted      = state_q == HALTED;
    assign o_Cycle_Step  = step_q;
    assign o_Cycle_Count = count_q;
    assign o_M_Index     = idx_q;
    assign o_Overrun     = overrun_q;
    // Vectors are cleared whenever RUN is left, so outputs come straight from the flops.
    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        count_d   = count_q;
        idx_d     = idx_q;
        overrun_d = overrun_q;
        case (state_q)
            IDLE: if (i_Enable) begin
                state_d = RUN;
                step_d  = STEPS'(1);
                count_d = MAX_CYCLES'(1);
                idx_d   = '0;
            end
            RUN: if (!stall) begin
                if (!step_q[STEPS-1]) begin
                    step_d = step_q << 1;
                end else if (!i_Enable || (i_Last_Cycle && i_Halt)) begin
                    state_d = i_Enable ? HALTED : IDLE;
                    step_d  = '0;
                    count_d = '0;
                    idx_d   = '0;
                end else if (i_Last_Cycle || count_q[MAX_CYCLES-1]) begin
                    step_d    = STEPS'(1);
                    count_d   = MAX_CYCLES'(1);
                    idx_d     = '0;
                    overrun_d = overrun_q | ~i_Last_Cycle;
                end else begin
                    step_d  = STEPS'(1);
                    count_d = count_q << 1;
                    idx_d   = idx_q + MW'(1);
                end
            end
            HALTED: if (!i_Enable) begin
                state_d = IDLE;
            end else if (i_Wake) begin
                state_d = RUN;
                step_d  = STEPS'(1);
                count_d = MAX_CYCLES'(1);
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge i_Clk or posedge i_Reset) begin
        if (i_Reset) begin
            state_q   <= IDLE;
            step_q    <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end
endmodule

// File: tb/tb_cycle_sequencer.sv
// tb_cycle_sequencer: scoreboard bench; default instance plus a STEPS=2,
// MAX_CYCLES=3, WAIT_STEP=1 instance, exercised one after the other.
module tb_cycle_sequencer;
    logic clk = 1'b0;
    logic rst_a = 1'b1, rst_b = 1'b1;
    logic en = 1'b0, wt = 1'b0, lst = 1'b0, hlt = 1'b0, wk = 1'b0;
    logic [3:0] step_a;
    logic [7:0] cnt_a;
    logic [2:0] idx_a;
    logic       ce_a, is_a, h_a, ov_a;
    logic [1:0] step_b;
    logic [2:0] cnt_b;
    logic [1:0] idx_b;
    logic       ce_b, is_b, h_b, ov_b;
    typedef struct {
        bit          d;
        logic [18:0] v;
        string       tag;
    } exp_t;
    exp_t q[$];
    int n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    cycle_sequencer dut_a (
        .i_Clk(clk), .i_Reset(rst_a), .i_Enable(en), .i_Wait(wt), .i_Last_Cycle(lst),
        .i_Halt(hlt), .i_Wake(wk), .o_Cycle_Step(step_a), .o_Cycle_Count(cnt_a),
        .o_M_Index(idx_a), .o_Cycle_End(ce_a), .o_Instr_Start(is_a), .o_Halted(h_a),
        .o_Overrun(ov_a)
    );
    cycle_sequencer #(.STEPS(2), .MAX_CYCLES(3), .WAIT_STEP(1)) dut_b (
        .i_Clk(clk), .i_Reset(rst_b), .i_Enable(en), .i_Wait(wt), .i_Last_Cycle(lst),
        .i_Halt(hlt), .i_Wake(wk), .o_Cycle_Step(step_b), .o_Cycle_Count(cnt_b),
        .o_M_Index(idx_b), .o_Cycle_End(ce_b), .o_Instr_Start(is_b), .o_Halted(h_b),
        .o_Overrun(ov_b)
    );
    function automatic logic [2:0] enc(input logic [7:0] c);
        logic [2:0] r = '0;
        for (int i = 0; i < 8; i++) if (c[i]) r = 3'(i);
        return r;
    endfunction
    // Drive one clock's inputs and queue the outputs that must be visible during that clock.
    task automatic cyc(input bit d, input logic rst, e, w, l, h, k, input logic [7:0] s, c,
                       input logic ce, is, hd, ov, input string tag);
        exp_t x;
        @(negedge clk);
        rst_a = d ? 1'b1 : rst;
        rst_b = d ? rst : 1'b1;
        en = e; wt = w; lst = l; hlt = h; wk = k;
        x.d = d;
        x.v = {s[3:0], c, enc(c), ce, is, hd, ov};
        x.tag = tag;
        q.push_back(x);
    endtask
    initial begin : monitor
        exp_t x;
        logic [18:0] act;
        forever begin
            @(negedge clk);
            #1;
            if (q.size() != 0) begin
                x = q.pop_front();
                act = x.d ? {2'b0, step_b, 5'b0, cnt_b, 1'b0, idx_b, ce_b, is_b, h_b, ov_b}
                          : {step_a, cnt_a, idx_a, ce_a, is_a, h_a, ov_a};
                n_cmp++;
                if (act !== x.v) begin
                    n_bad++;
                    $display("FAIL %s: got %h expected %h", x.tag, act, x.v);
                end
            end
        end
    end
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end
    initial begin : stim
        int st[7] = '{1, 2, 2, 2, 2, 4, 8};
        int ws[7] = '{0, 1, 1, 1, 0, 0, 0};
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_en");
        for (int j = 0; j < 16; j++)
            cyc(0, 0, 1, 0, (j / 4) % 2 == 1, 0, 0, 8'(1 << (j % 4)), 8'(1 << ((j / 4) % 2)),
                j % 4 == 3, j % 8 == 0, 0, 0, "normal");
        for (int i = 0; i < 7; i++)
            cyc(0, 0, 1, ws[i] == 1, 0, 0, 0, 8'(st[i]), 8'd1, i == 6, i == 0, 0, 0, "wait");
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 1, 0, 1, 0, 0, 8'(1 << k), 8'd2, k == 3, 0, 0, 0, "wait_next");
        for (int j = 0; j < 32; j++)
            cyc(0, 0, 1, 0, 0, 0, 0, 8'(1 << (j % 4)), 8'(1 << (j / 4)), j % 4 == 3, j == 0, 0, 0,
                "overrun_walk");
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 1, 0, 1, 0, 0, 8'(1 << k), 8'd1, k == 3, k == 0, 0, 1, "overrun_wrap");
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 1, 0, 1, k == 3, k == 3, 8'(1 << k), 8'd1, k == 3, k == 0, 0, 1, "pre_halt");
        for (int i = 0; i < 6; i++)
            cyc(0, 0, 1, 0, 0, 0, i == 5, 0, 0, 0, 0, 1, 1, "halted");
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 1, 0, 0, 1, 0, 8'(1 << k), 8'd1, k == 3, k == 0, 0, 1, "halt_nolast");
        for (int k = 0; k < 4; k++)
            cyc(0, 0, k == 0, 0, 0, 0, 0, 8'(1 << k), 8'd2, k == 3, 0, 0, 1, "en_drop");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "idle");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "idle");
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, "idle_en2");
        for (int k = 0; k < 4; k++)
            cyc(0, 0, 1, 0, 0, 0, 0, 8'(1 << k), 8'd1, k == 3, k == 0, 0, 1, "pre_reset");
        for (int k = 0; k < 2; k++)
            cyc(0, 0, 1, 0, 0, 0, 0, 8'(1 << k), 8'd2, 0, 0, 0, 1, "pre_reset2");
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "async_reset");
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "reset_hold");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "post_reset");
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_no_en");
        cyc(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "idle_en3");
        cyc(0, 0, 1, 0, 0, 0, 0, 8'd1, 8'd1, 0, 1, 0, 0, "restart");
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "b_reset");
        cyc(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "b_idle_en");
        for (int j = 0; j < 6; j++)
            cyc(1, 0, 1, 0, 0, 0, 0, 8'(1 << (j % 2)), 8'(1 << (j / 2)), j % 2 == 1, j == 0, 0, 0,
                "b_walk");
        cyc(1, 0, 1, 0, 0, 0, 0, 8'd1, 8'd1, 0, 1, 0, 1, "b_overrun");
        cyc(1, 0, 1, 1, 0, 0, 0, 8'd2, 8'd1, 0, 0, 0, 1, "b_stall");
        cyc(1, 0, 1, 0, 0, 0, 0, 8'd2, 8'd1, 1, 0, 0, 1, "b_stall_end");
        cyc(1, 0, 1, 0, 0, 0, 0, 8'd1, 8'd2, 0, 0, 0, 1, "b_next");
        @(negedge clk);
        #2;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_leftover: got %0d expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cycle_sequencer.md
# cycle_sequencer

Parametrised T-state / M-cycle timing generator for the CPU control unit. Produces the one-hot step and cycle-count vectors that every opcode-group decoder consumes. The decoder in control reports when the current M-cycle is the instruction's last, and the sequencer wraps to the next fetch at that point. Adds memory wait-state stalling, HALT/wake handling, and a sticky overrun flag for instructions that never report their last cycle.

## Interface
- STEPS, 4: T-states per M-cycle; width of o_Cycle_Step; must be ≥2.
- MAX_CYCLES, 8: maximum M-cycles per instruction; width of o_Cycle_Count; must be ≥2.
- WAIT_STEP, 1: step index (0-based) at which i_Wait is honoured; must be < STEPS.
- i_Clk  in  1  single clock; all state changes on its rising edge.
- i_Reset  in  1  asynchronous, active-high reset.
- i_Enable  in  1  run request from top level; sampled only at M-cycle boundaries, except in IDLE.
- i_Wait  in  1  bus wait-state; holds the step vector while at WAIT_STEP.
- i_Last_Cycle  in  1  decoder flag: current M-cycle is the instruction's final one; sampled on the final step.
- i_Halt  in  1  HALT request; sampled on the final step of a last cycle.
- i_Wake  in  1  interrupt/wake from HALTED; level-sensitive.
- o_Cycle_Step  out  STEPS  one-hot current T-state; all zero outside RUN.
- o_Cycle_Count  out  MAX_CYCLES  one-hot current M-cycle; all zero outside RUN.
- o_M_Index  out  $clog2(MAX_CYCLES)  binary index of o_Cycle_Count; 0 outside RUN.
- o_Cycle_End  out  1  high during the final, unstalled step of each M-cycle in RUN.
- o_Instr_Start  out  1  high during step 0 of M-cycle 0 in RUN (fetch slot).
- o_Halted  out  1  high in HALTED.
- o_Overrun  out  1  sticky; set when MAX_CYCLES completes without i_Last_Cycle.

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE with every output 0 and o_Overrun cleared.
- IDLE: if i_Enable = 1 → RUN, step = bit0, count = bit0.
- RUN, step k < STEPS-1: advance to step k+1. Exception: k = WAIT_STEP and i_Wait = 1, which holds step k.
- RUN, final step (stall applies if WAIT_STEP = STEPS-1): o_Cycle_End = 1. Next state is chosen by the first matching rule below, and step returns to bit0 in every case:
  1. If i_Enable = 0 → IDLE.
  2. Else if i_Last_Cycle = 1 and i_Halt = 1 → HALTED.
  3. Else if i_Last_Cycle = 1 → count = bit0 (next instruction fetch).
  4. Else if count = bit MAX_CYCLES-1 → set o_Overrun, count = bit0.
  5. Else count shifts left one bit.
- i_Halt with i_Last_Cycle = 0 is ignored.
- HALTED: step and count outputs are zero.
  - If i_Enable = 0 → IDLE.
  - Else if i_Wake = 1 → RUN at step bit0, count bit0.
- o_Overrun is cleared only by reset.
- Invariant: in RUN, exactly one bit of o_Cycle_Step and exactly one bit of o_Cycle_Count are set.
- o_M_Index always equals the encoded position of the o_Cycle_Count bit.

## Timing
- All state is registered. o_Cycle_End, o_Instr_Start and o_Halted decode combinationally from registered state plus i_Wait; no input-to-output path exists otherwise.
- Enable latency: i_Enable high in IDLE at edge n → step/count = bit0 after edge n.
- Unstalled M-cycle = STEPS clocks. Each wait clock adds exactly 1 clock.
- Instruction of N M-cycles = N·STEPS clocks, plus wait clocks, fetch to fetch.
- Wake latency: 1 clock. i_Wake in the same clock as the HALTED entry edge has no effect; it must be sampled while in HALTED.
- Asynchronous reset mid-instruction forces IDLE and zero outputs immediately. First step after deassertion requires i_Enable.

## Test plan
- Defaults, i_Enable = 1, i_Last_Cycle high on M-cycle 1 → step 1,2,4,8 repeats; count 1,2,1,2…; o_Instr_Start every 8 clocks; o_Cycle_End on clocks 4 and 8.
- i_Wait = 1 for 3 clocks at step bit1 → step holds 0010 for 4 clocks total; M-cycle takes 7 clocks; o_Cycle_End not asserted during stall.
- i_Last_Cycle never set, MAX_CYCLES = 8 → count walks 0x01…0x80; o_Overrun rises after 32 clocks, stays high; count wraps to 0x01.
- i_Halt + i_Last_Cycle on final step → next clock o_Halted = 1, vectors 0. i_Wake pulsed 5 clocks later → next clock step = 1, count = 1.
- i_Enable dropped mid-M-cycle at step 2 → sequence completes step 8, then IDLE with zero outputs. i_Halt without i_Last_Cycle → no halt.
- Reset asserted at step 4, count 2 → outputs 0 asynchronously. Check again with STEPS = 2, MAX_CYCLES = 3, WAIT_STEP = 1: wraps and overrun after 6 clocks.
